// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NUM_REQ
// valid/ready requesters, with a one-entry registered write stage and a stall freeze.
module rf_wr_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int REG_WIDTH  = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*REG_WIDTH-1:0]    req_data,
   input  logic                            stall,
   output logic                            wr_en,
   output logic [ADDR_WIDTH-1:0]           wr_addr,
   output logic [REG_WIDTH-1:0]            wr_data,
   output logic [1:0]                      wr_src,
   output logic                            busy,
   output logic                            err
);

   logic [1:0]            rr_ptr;
   logic [1:0]            ptr_eff;
   logic                  out_valid;

   logic                  hi_found;
   logic [1:0]            hi_idx;
   logic                  lo_found;
   logic [1:0]            lo_idx;
   logic                  gnt_found;
   logic [1:0]            gnt_idx;
   logic [1:0]            next_ptr;
   logic                  accept;

   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [REG_WIDTH-1:0]  sel_data;

   // Out-of-range pointer values cannot be reached, but fall back to 0 if they ever are.
   assign ptr_eff = (int'(rr_ptr) >= NUM_REQ) ? 2'd0 : rr_ptr;

   // Two-pass priority: lowest valid index at or above the pointer, else lowest overall.
   // Scanning downward leaves the lowest matching index in each result.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = 2'd0;
      lo_found = 1'b0;
      lo_idx   = 2'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_found = 1'b1;
            lo_idx   = 2'(i);
            if (i >= int'(ptr_eff)) begin
               hi_found = 1'b1;
               hi_idx   = 2'(i);
            end
         end
      end
   end

   assign gnt_found = lo_found;
   assign gnt_idx   = hi_found ? hi_idx : lo_idx;
   assign next_ptr  = (int'(gnt_idx) == NUM_REQ - 1) ? 2'd0 : gnt_idx + 2'd1;

   // While in reset nothing may be accepted, so the grant is qualified with rst as well.
   assign accept = gnt_found & ~stall & rst;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = accept && (gnt_idx == 2'(i));
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == 2'(i)) begin
            sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req_data[i*REG_WIDTH +: REG_WIDTH];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr    <= 2'd0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         if (gnt_found) begin
            rr_ptr    <= next_ptr;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   // Payload only loads on an accept; it otherwise holds its last value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_addr <= '0;
         wr_data <= '0;
         wr_src  <= 2'd0;
      end else if (accept) begin
         wr_addr <= sel_addr;
         wr_data <= sel_data;
         wr_src  <= gnt_idx;
      end
   end

   assign wr_en = out_valid & ~stall;
   assign busy  = out_valid;

   // Simulation-visible fault flag; it never feeds back into state.
   assign err = $isunknown(req_valid) || (gnt_found && !stall && $isunknown(sel_addr));

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single write port of the 16-bit register file among NUM_REQ requesters, e.g. ALU writeback, load return and a multi-cycle unit.
- Each requester uses a valid/ready handshake; a round-robin pointer selects one winner per cycle.
- The winner's address and data are captured into a registered write stage that drives the register file write port one cycle later.
- A stall input freezes the arbiter while the register file port is unavailable.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
REG_WIDTH, 16, data width of a register
ADDR_WIDTH, 3, register-address width (8 registers)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_addr  in  NUM_REQ*ADDR_WIDTH  packed destination register, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NUM_REQ*REG_WIDTH  packed write data, requester i at [i*REG_WIDTH +: REG_WIDTH]
stall  in  1  register file port unavailable; freeze arbiter
wr_en  out  1  register file write enable
wr_addr  out  ADDR_WIDTH  register file write address
wr_data  out  REG_WIDTH  register file write data
wr_src  out  2  index of the requester owning the current write
busy  out  1  write stage holds a valid entry
err  out  1  X/Z detected on a request

Behaviour:
- Reset (rst=0, async): rr_ptr=0, out_valid=0, wr_addr=0, wr_data=0, wr_src=0. Hence wr_en=0, busy=0, req_ready=0. A pending write is dropped and never issued.
- Arbitration is combinational each cycle with stall=0. Search req_valid starting at index rr_ptr, ascending, wrapping NUM_REQ-1 -> 0. The first set bit wins and its req_ready is 1; all other req_ready bits are 0.
- req_ready is never asserted for a requester whose req_valid is 0.
- Transfer occurs when req_valid[i] & req_ready[i] are both high at the rising edge. On the next edge:
  - out_valid<=1, wr_addr<=req_addr[i], wr_data<=req_data[i], wr_src<=i.
  - rr_ptr<=(i+1) mod NUM_REQ.
- No requester valid (stall=0): out_valid<=0, rr_ptr unchanged, wr_addr/wr_data/wr_src hold.
- Latency: exactly 1 cycle from accept to wr_en=1. Throughput: 1 write per cycle.
- wr_en = out_valid & ~stall. busy = out_valid.
- stall=1:
  - All req_ready=0.
  - out_valid, wr_addr, wr_data, wr_src and rr_ptr hold.
  - wr_en=0, so the held entry is written in the first cycle after stall drops.
  - In that cycle the arbiter may accept a new request, which replaces the held entry on the following edge.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of non-stalled operation.
- Requesters must hold req_valid, req_addr and req_data stable until accepted.
- Two requesters targeting the same register are serialized in grant order. The later grant is the final value.
- err (combinational, 1 = fault):
  - Any req_valid bit is X/Z.
  - Or the granted requester's req_addr contains X/Z.
  - err has no effect on state.
- Width: rr_ptr is 2 bits. Values >= NUM_REQ are unreachable; if reached they are treated as 0.

Test Plan:
- Reset then single request: rst 0->1, req_valid=3'b001, addr=3, data=16'hBEEF for 1 cycle -> req_ready=3'b001 that cycle; next cycle wr_en=1, wr_addr=3, wr_data=16'hBEEF, wr_src=0; following cycle wr_en=0.
- Round-robin: req_valid=3'b111 held 6 cycles, data=16'h0A00+i -> grant order 0,1,2,0,1,2; wr_src follows one cycle later; wr_en=1 on 6 consecutive cycles.
- Wrap and skip: rr_ptr=2 (after a grant to 1), req_valid=3'b011 -> requester 0 granted, then 1; requester 2 never granted.
- Stall: request accepted with addr=5, data=16'h1234, then stall=1 for 3 cycles while req_valid=3'b110 -> wr_en=0, busy=1, req_ready=0, wr_addr=5 held. After stall=0: wr_en=1 with 16'h1234 that cycle, requester 1 granted.
- Reset mid-operation: accept a request, assert rst=0 before the next edge -> wr_en=0 immediately and no write occurs; after release the first grant goes to requester 0.
- X check: req_valid=3'b0x1 -> err=1; all valid bits known with defined addr -> err=0.
